pic_responder: RTL

- Peripheral-side 8-line programmable interrupt controller; the responder for the core's toggle-handshake interrupt interface (intr/intl/irq) and its 8-bit port bus.
- Latches device request edges, arbitrates by fixed priority and presents an 8-bit vector to the core.
- Tracks in-service levels until software issues EOI through port writes.
- Sits beside the core in the system top; ports use the core's names so wiring is direct.

---
 rtl/pic_pkg.sv | 27 ++
 rtl/pic_prio_enc.sv | 19 +
 rtl/pic_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared constants and types for the programmable interrupt controller.
package pic_pkg;

  localparam int unsigned NLINES = 8;
  localparam int unsigned IDX_W  = 3;

  // Register offsets relative to BASE
  localparam logic [1:0] REG_CMD = 2'd0;
  localparam logic [1:0] REG_IMR = 2'd1;
  localparam logic [1:0] REG_ISR = 2'd2;
  localparam logic [1:0] REG_VEC = 2'd3;

  // EOI opcodes carried in port_o[7:5] of a REG_CMD write
  localparam logic [2:0] EOI_NS = 3'b001;
  localparam logic [2:0] EOI_SP = 3'b011;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  // One-hot mask for an interrupt level
  function automatic logic [NLINES-1:0] level_mask(input logic [IDX_W-1:0] lvl);
    return NLINES'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-set-bit encoder: bit 0 is the highest priority level.
module pic_prio_enc
  import pic_pkg::*;
(
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from the top down so the lowest set bit is the last to write idx
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pic_responder.sv
// Peripheral-side 8-line interrupt controller answering the core's
// toggle handshake (intr/intl/irq) and exposing IRR/IMR/ISR/VBASE on the port bus.
module pic_responder
  import pic_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'h0020,
  parameter logic [7:0]  VBASE_RST = 8'h08
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq_lines,
  input  logic [15:0] port,
  input  logic        port_clk,
  input  logic        port_w,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  output logic [7:0]  irq,
  output logic        intr,
  input  logic        intl
);

  state_e      state_q, state_d;
  logic [7:0]  lines_q, lines_d;
  logic [7:0]  irr_q, irr_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  imr_q, imr_d;
  logic [7:0]  vbase_q, vbase_d;
  logic [7:0]  vec_q, vec_d;
  logic        intr_q, intr_d;
  logic        port_clk_q, port_clk_d;

  logic        in_range;
  logic [1:0]  offset;
  logic        wr_stb;
  logic [7:0]  cand;
  logic [2:0]  cand_idx, isr_idx;
  logic        cand_vld, isr_vld;
  logic        can_dispatch;
  logic        dispatch;
  logic [7:0]  disp_mask;
  logic [7:0]  eoi_clr;

  pic_prio_enc u_cand_enc (
    .req   (cand),
    .idx   (cand_idx),
    .valid (cand_vld)
  );

  pic_prio_enc u_isr_enc (
    .req   (isr_q),
    .idx   (isr_idx),
    .valid (isr_vld)
  );

  // Port address decode and write strobe on the rising edge of port_clk
  always_comb begin
    in_range   = (port >= BASE) && (port <= (BASE + 16'd3));
    offset     = 2'(port - BASE);
    port_clk_d = port_clk;
    wr_stb     = port_clk && !port_clk_q && in_range && port_w;
  end

  // Side-effect-free register readback
  always_comb begin
    port_i = 8'h00;
    if (in_range) begin
      case (offset)
        REG_CMD: port_i = irr_q;
        REG_IMR: port_i = imr_q;
        REG_ISR: port_i = isr_q;
        default: port_i = {vbase_q[7:3], 3'b000};
      endcase
    end
  end

  // Arbitration: lowest unmasked request must outrank every in-service level
  always_comb begin
    cand         = irr_q & ~imr_q;
    can_dispatch = cand_vld && (!isr_vld || (cand_idx < isr_idx));
  end

  // Handshake FSM: dispatch from IDLE, wait in PEND until intl catches up
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    intr_d   = intr_q;
    dispatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_dispatch) begin
          dispatch = 1'b1;
          vec_d    = {vbase_q[7:3], cand_idx};
          intr_d   = ~intr_q;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (intl == intr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register updates: edge capture, EOI clears, dispatch sets (sets win)
  always_comb begin
    lines_d   = irq_lines;
    disp_mask = dispatch ? level_mask(cand_idx) : 8'h00;
    eoi_clr   = 8'h00;
    imr_d     = imr_q;
    vbase_d   = vbase_q;
    if (wr_stb) begin
      case (offset)
        REG_CMD: begin
          if (port_o[7:5] == EOI_NS && isr_vld) eoi_clr = level_mask(isr_idx);
          else if (port_o[7:5] == EOI_SP)       eoi_clr = level_mask(port_o[2:0]);
        end
        REG_IMR: imr_d   = port_o;
        REG_VEC: vbase_d = port_o & 8'hF8;
        default: ;
      endcase
    end
    irr_d = (irr_q & ~disp_mask) | (irq_lines & ~lines_q);
    isr_d = (isr_q & ~eoi_clr) | disp_mask;
  end

  // State and register flops with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      lines_q    <= irq_lines;
      irr_q      <= 8'h00;
      isr_q      <= 8'h00;
      imr_q      <= 8'hFF;
      vbase_q    <= VBASE_RST & 8'hF8;
      vec_q      <= 8'h00;
      intr_q     <= intl;
      port_clk_q <= port_clk;
    end else begin
      state_q    <= state_d;
      lines_q    <= lines_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      vbase_q    <= vbase_d;
      vec_q      <= vec_d;
      intr_q     <= intr_d;
      port_clk_q <= port_clk_d;
    end
  end

  assign irq  = vec_q;
  assign intr = intr_q;

endmodule
